uv_line_buffer: RTL and testbench
=================================

// Module: uv_line_buffer
// PURPOSE
//  Ping-pong line buffer between the UV interpolator (rasterizer) and the pixel shader.
//  Rasterizer fills one bank with per-pixel {U,V,tex} words for the next line.
//  Shader reads the other bank by pixel address, with 1-cycle read latency.
//  Banks swap on the shader's Line_Start pulse. Replaces the generated-pattern UV stub on the shader side.
// PARAMETERS
//  ADDR_W       11        pixel address width; bank depth = 2**ADDR_W words
//  DATA_W       32        UV word width: {U[11:0],V[11:0],B[7:0]}
//  CLEAR_VALUE  32'h0     read-return value when the read bank is invalid
// PORTS
//  clk100          in   1       system clock; all logic on posedge
//  rst             in   1       synchronous, active-high reset
//  Raster_UV_Valid in   1       write word present
//  Raster_UV_Ready out  1       buffer accepts write; transfer = Valid & Ready
//  Raster_UV_Addr  in   ADDR_W  pixel address of write word
//  Raster_UV_Data  in   DATA_W  UV word
//  Raster_UV_Last  in   1       marks the final word of the line
//  Raster_UV_Line  in   10      line number; sampled on the first transfer of a line
//  Line_Start      in   1       one-cycle pulse from shader: begin reading the next line
//  Line            in   10      line number the shader is about to read; sampled with Line_Start
//  Shader_UV_Addr  in   ADDR_W  read address
//  UV_Shader_Data  out  DATA_W  registered read data, valid 1 cycle after the address
//  Read_Valid      out  1       read bank holds a completed line
//  Underrun_Count  out  8       saturating count of Line_Start pulses with no completed line
//  Line_Mismatch   out  1       sticky: a swapped line's tag differed from Line
// BEHAVIOUR
//  Reset: wr_bank=0; fill FSM=FILL; Raster_UV_Ready=0 during rst, 1 on the first cycle after rst.
//   UV_Shader_Data=0, Read_Valid=0, Underrun_Count=0, Line_Mismatch=0. RAM contents are not reset.
//  Fill FSM (write bank = wr_bank; read bank = ~wr_bank):
//   FILL: Ready=1. A transfer writes Data to Addr in the write bank.
//    The first transfer after entering FILL latches Raster_UV_Line into tag.
//    A transfer with Last moves the FSM to DONE.
//   DONE: Ready=0; holds until Line_Start.
//  Line_Start with FSM in DONE, or in FILL with a Last transfer in the same cycle:
//   toggle wr_bank; FSM->FILL; Read_Valid<=1.
//   If tag!=Line, Line_Mismatch<=1 (the swap still happens).
//   The Last word is written before the swap and belongs to the line being released.
//  Line_Start without a completed line: no swap; Read_Valid<=0.
//   Underrun_Count += 1, saturating at 255. Fill continues into the same bank.
//  Read: UV_Shader_Data <= Read_Valid ? bank[~wr_bank][Shader_UV_Addr] : CLEAR_VALUE. Latency 1.
//   On the swap cycle, the read mux takes the new read bank from the next edge onward.
//  Address wrap: none; every ADDR_W value is a legal address. Duplicate writes: last write wins.
//  Writes are unconditional on Addr; reads never stall; no backpressure on the shader.
//  rst mid-line: the partial line is discarded, Read_Valid=0, counters cleared.
// CONFIGURATION
//  UVBUF_CLEAR_EN defined: each bank keeps a 2**ADDR_W-bit written bitmap.
//   A transfer sets its bit. Reads of an entry whose bit is clear return CLEAR_VALUE.
//   The new write bank's bitmap is cleared on the swap cycle; both bitmaps are cleared on rst.
//  UVBUF_CLEAR_EN undefined: no bitmap; unwritten entries return stale RAM data.
// STRUCTURE
//  uvbuf_pkg: ADDR_W/DATA_W defaults, fill-state enum {FILL, DONE}, UV word field offsets.
//  Sub-module uv_bank_ram: simple dual-port RAM, 1 write port, registered read.
//   Instantiated twice (one per bank).
//  Top level holds the FSM, bank select, tag compare, counters and the read mux.
// TESTING
//  1. rst 3 cycles -> Ready=0 during rst, 1 after; Read_Valid=0; UV_Shader_Data=0.
//  2. Fill line 5: addr 0..1279, data=addr, Last at 1279; Line_Start with Line=5
//     -> Read_Valid=1; read addr 100 gives 100 next cycle; Line_Mismatch=0.
//  3. Line_Start before Last -> no swap, Read_Valid=0, reads return 0, Underrun_Count=1.
//     Finish the line, next Line_Start -> swap.
//  4. Last transfer and Line_Start in the same cycle -> swap.
//     The Last word is readable at its address from the next cycle.
//  5. Fill tagged 7, Line_Start with Line=8 -> swap occurs, Line_Mismatch=1 and stays set.
//  6. UVBUF_CLEAR_EN: write only addr 0..9, swap; read addr 10 -> CLEAR_VALUE.
//     Without the macro, read addr 10 returns the prior contents.

Source files
------------

// File: rtl/uvbuf_pkg.sv
// Shared definitions for the UV line buffer: default widths,
// fill-state encoding and UV word field offsets.
package uvbuf_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  // UV word layout: {U[11:0], V[11:0], B[7:0]}
  localparam int U_LSB = 20;
  localparam int U_W   = 12;
  localparam int V_LSB = 8;
  localparam int V_W   = 12;
  localparam int B_LSB = 0;
  localparam int B_W   = 8;

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } fill_state_e;

endpackage

// File: rtl/uv_bank_ram.sv
// One bank of the line buffer: simple dual-port RAM, one write
// port, registered read. Ports: clk, we/waddr/wdata, raddr, rdata.
module uv_bank_ram
  import uvbuf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uv_line_buffer.sv
// Ping-pong UV line buffer between rasterizer (writer) and shader
// (reader). Ports: clk100/rst, Raster_UV_* write handshake,
// Line_Start/Line swap request, Shader_UV_Addr/UV_Shader_Data
// read port, Read_Valid, Underrun_Count, Line_Mismatch.
// Build option UVBUF_CLEAR_EN: per-bank written bitmap, unwritten
// entries read back as CLEAR_VALUE.
module uv_line_buffer
  import uvbuf_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              Raster_UV_Valid,
  output logic              Raster_UV_Ready,
  input  logic [ADDR_W-1:0] Raster_UV_Addr,
  input  logic [DATA_W-1:0] Raster_UV_Data,
  input  logic              Raster_UV_Last,
  input  logic [9:0]        Raster_UV_Line,
  input  logic              Line_Start,
  input  logic [9:0]        Line,
  input  logic [ADDR_W-1:0] Shader_UV_Addr,
  output logic [DATA_W-1:0] UV_Shader_Data,
  output logic              Read_Valid,
  output logic [7:0]        Underrun_Count,
  output logic              Line_Mismatch
);

  fill_state_e state_q, state_d;

  logic              wr_bank;
  logic              first_q;
  logic [9:0]        tag_q;
  logic [9:0]        tag_now;
  logic              xfer;
  logic              last_xfer;
  logic              done_line;
  logic              swap;
  logic              underrun;
  logic              rv_q;
  logic              sel_q;
  logic [DATA_W-1:0] q0, q1;
  logic [DATA_W-1:0] rd_word;

  assign xfer      = Raster_UV_Valid & Raster_UV_Ready;
  assign last_xfer = xfer & Raster_UV_Last;
  assign done_line = (state_q == DONE) | last_xfer;
  assign swap      = Line_Start & done_line;
  assign underrun  = Line_Start & ~done_line;

  // A one-word line latches and releases its tag in the same cycle
  assign tag_now = first_q ? Raster_UV_Line : tag_q;

  always_comb begin
    state_d         = state_q;
    Raster_UV_Ready = 1'b0;
    unique case (state_q)
      FILL: begin
        Raster_UV_Ready = ~rst;
        if (last_xfer && !swap) state_d = DONE;
      end
      DONE: begin
        if (swap) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q        <= FILL;
      wr_bank        <= 1'b0;
      first_q        <= 1'b1;
      tag_q          <= '0;
      Read_Valid     <= 1'b0;
      Underrun_Count <= '0;
      Line_Mismatch  <= 1'b0;
      rv_q           <= 1'b0;
      sel_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= Read_Valid;
      sel_q   <= ~wr_bank;
      if (xfer && first_q) begin
        tag_q   <= Raster_UV_Line;
        first_q <= 1'b0;
      end
      if (swap) begin
        wr_bank    <= ~wr_bank;
        Read_Valid <= 1'b1;
        first_q    <= 1'b1;
        if (tag_now != Line) Line_Mismatch <= 1'b1;
      end
      if (underrun) begin
        Read_Valid <= 1'b0;
        if (Underrun_Count != 8'hFF)
          Underrun_Count <= Underrun_Count + 8'd1;
      end
    end
  end

  uv_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
    .clk   (clk100),
    .we    (xfer & ~wr_bank),
    .waddr (Raster_UV_Addr),
    .wdata (Raster_UV_Data),
    .raddr (Shader_UV_Addr),
    .rdata (q0)
  );

  uv_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
    .clk   (clk100),
    .we    (xfer & wr_bank),
    .waddr (Raster_UV_Addr),
    .wdata (Raster_UV_Data),
    .raddr (Shader_UV_Addr),
    .rdata (q1)
  );

  assign rd_word = sel_q ? q1 : q0;

`ifdef UVBUF_CLEAR_EN
  logic [2**ADDR_W-1:0] map0, map1;
  logic                 hit_q;

  // The bank about to become the write bank starts with no entries
  always_ff @(posedge clk100) begin
    if (rst) begin
      map0  <= '0;
      map1  <= '0;
      hit_q <= 1'b0;
    end else begin
      if (swap) begin
        if (wr_bank) map0 <= '0;
        else         map1 <= '0;
      end
      if (xfer) begin
        if (wr_bank) map1[Raster_UV_Addr] <= 1'b1;
        else         map0[Raster_UV_Addr] <= 1'b1;
      end
      hit_q <= wr_bank ? map0[Shader_UV_Addr]
                       : map1[Shader_UV_Addr];
    end
  end

  assign UV_Shader_Data = (rv_q && hit_q) ? rd_word : CLEAR_VALUE;
`else
  assign UV_Shader_Data = rv_q ? rd_word : CLEAR_VALUE;
`endif

endmodule

// File: tb/tb_uv_line_buffer.sv
// Directed self-checking bench for uv_line_buffer.
// Covers reset, fill/swap, underrun, same-cycle swap, tag mismatch.
module tb_uv_line_buffer;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk100 = 1'b0;
  logic          rst;
  logic          Raster_UV_Valid;
  logic          Raster_UV_Ready;
  logic [AW-1:0] Raster_UV_Addr;
  logic [DW-1:0] Raster_UV_Data;
  logic          Raster_UV_Last;
  logic [9:0]    Raster_UV_Line;
  logic          Line_Start;
  logic [9:0]    Line;
  logic [AW-1:0] Shader_UV_Addr;
  logic [DW-1:0] UV_Shader_Data;
  logic          Read_Valid;
  logic [7:0]    Underrun_Count;
  logic          Line_Mismatch;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  uv_line_buffer #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VALUE('0)) dut (
    .clk100          (clk100),
    .rst             (rst),
    .Raster_UV_Valid (Raster_UV_Valid),
    .Raster_UV_Ready (Raster_UV_Ready),
    .Raster_UV_Addr  (Raster_UV_Addr),
    .Raster_UV_Data  (Raster_UV_Data),
    .Raster_UV_Last  (Raster_UV_Last),
    .Raster_UV_Line  (Raster_UV_Line),
    .Line_Start      (Line_Start),
    .Line            (Line),
    .Shader_UV_Addr  (Shader_UV_Addr),
    .UV_Shader_Data  (UV_Shader_Data),
    .Read_Valid      (Read_Valid),
    .Underrun_Count  (Underrun_Count),
    .Line_Mismatch   (Line_Mismatch)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  // Writes addresses start..start+n-1 with data base+addr
  task automatic fill(input int line, input int start, input int n,
                      input int base, input bit last);
    for (int i = start; i < start + n; i++) begin
      Raster_UV_Valid = 1'b1;
      Raster_UV_Addr  = AW'(i);
      Raster_UV_Data  = DW'(base + i);
      Raster_UV_Line  = 10'(line);
      Raster_UV_Last  = last && (i == start + n - 1);
      tick();
    end
    Raster_UV_Valid = 1'b0;
    Raster_UV_Last  = 1'b0;
  endtask

  task automatic pulse(input int ln);
    Line_Start = 1'b1;
    Line       = 10'(ln);
    tick();
    Line_Start = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    Shader_UV_Addr = AW'(a);
    tick();
    d = UV_Shader_Data;
  endtask

  logic [31:0] d;

  initial begin
    rst             = 1'b1;
    Raster_UV_Valid = 1'b0;
    Raster_UV_Addr  = '0;
    Raster_UV_Data  = '0;
    Raster_UV_Last  = 1'b0;
    Raster_UV_Line  = '0;
    Line_Start      = 1'b0;
    Line            = '0;
    Shader_UV_Addr  = '0;

    // reset
    repeat (3) begin
      tick();
      check("ready_in_rst", 32'(Raster_UV_Ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(Raster_UV_Ready), 32'd1);
    check("rv_reset", 32'(Read_Valid), 32'd0);
    check("data_reset", UV_Shader_Data, 32'd0);
    check("underrun_reset", 32'(Underrun_Count), 32'd0);
    check("mismatch_reset", 32'(Line_Mismatch), 32'd0);

    // full line 5, bank 0
    fill(5, 0, 1280, 0, 1'b1);
    check("ready_done", 32'(Raster_UV_Ready), 32'd0);
    pulse(5);
    check("rv_swap1", 32'(Read_Valid), 32'd1);
    check("ready_refill", 32'(Raster_UV_Ready), 32'd1);
    rd(100, d);  check("rd_l5_100", d, 32'd100);
    rd(0, d);    check("rd_l5_0", d, 32'd0);
    rd(1279, d); check("rd_l5_1279", d, 32'd1279);
    check("mismatch_l5", 32'(Line_Mismatch), 32'd0);

    // underrun mid-line, bank 1
    fill(6, 0, 600, 32'h1000, 1'b0);
    pulse(6);
    check("rv_underrun", 32'(Read_Valid), 32'd0);
    check("underrun_1", 32'(Underrun_Count), 32'd1);
    rd(100, d);  check("rd_underrun", d, 32'd0);
    fill(6, 600, 680, 32'h1000, 1'b1);
    pulse(6);
    check("rv_swap2", 32'(Read_Valid), 32'd1);
    rd(100, d);  check("rd_l6_100", d, 32'h1000 + 100);
    rd(700, d);  check("rd_l6_700", d, 32'h1000 + 700);
    check("mismatch_l6", 32'(Line_Mismatch), 32'd0);

    // Last and Line_Start together, bank 0
    fill(7, 0, 1279, 32'h2000, 1'b0);
    Raster_UV_Valid = 1'b1;
    Raster_UV_Addr  = AW'(1279);
    Raster_UV_Data  = 32'h2000 + 1279;
    Raster_UV_Last  = 1'b1;
    Line_Start      = 1'b1;
    Line            = 10'd7;
    tick();
    Raster_UV_Valid = 1'b0;
    Raster_UV_Last  = 1'b0;
    Line_Start      = 1'b0;
    check("rv_swap3", 32'(Read_Valid), 32'd1);
    check("ready_same_cycle", 32'(Raster_UV_Ready), 32'd1);
    rd(1279, d); check("rd_l7_last", d, 32'h2000 + 1279);
    rd(5, d);    check("rd_l7_5", d, 32'h2005);
    check("underrun_hold", 32'(Underrun_Count), 32'd1);
    check("mismatch_l7", 32'(Line_Mismatch), 32'd0);

    // tag 7 released as line 8, bank 1
    fill(7, 0, 1280, 32'h3000, 1'b1);
    pulse(8);
    check("rv_swap4", 32'(Read_Valid), 32'd1);
    check("mismatch_set", 32'(Line_Mismatch), 32'd1);
    rd(100, d);  check("rd_l8_100", d, 32'h3000 + 100);

    // partial rewrite of bank 0
    fill(9, 0, 10, 32'h4000, 1'b1);
    pulse(9);
    check("mismatch_sticky", 32'(Line_Mismatch), 32'd1);
    rd(5, d);    check("rd_l9_5", d, 32'h4005);
    rd(9, d);    check("rd_l9_9", d, 32'h4009);
    rd(10, d);
`ifdef UVBUF_CLEAR_EN
    check("rd_unwritten", d, 32'd0);
`else
    check("rd_unwritten", d, 32'h2000 + 10);
`endif

    // reset mid-line
    fill(10, 0, 3, 32'h5000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rv_midrst", 32'(Read_Valid), 32'd0);
    check("underrun_midrst", 32'(Underrun_Count), 32'd0);
    check("mismatch_midrst", 32'(Line_Mismatch), 32'd0);
    check("ready_midrst", 32'(Raster_UV_Ready), 32'd1);
    rd(1, d);    check("rd_midrst", d, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
